// File: rtl/nanomamba_snr_frame_collector_if.sv
// Bus bundle for nanomamba_snr_frame_collector.
// Carries the SNR sample stream (snr_in/snr_index/snr_valid/snr_frame_done),
// the random-access read port (rd_en/rd_addr/rd_data), the release
// handshake (frame_avail/frame_release/rd_seq) and the drop/statistics
// outputs (err_drop/drop_count/stat_mean/stat_min).
// The master modport is the producer/consumer side; the slave modport is
// the collector itself.
interface nanomamba_snr_frame_collector_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] snr_in;
  logic [5:0]            snr_index;
  logic                  snr_valid;
  logic                  snr_frame_done;
  logic                  frame_avail;
  logic                  rd_en;
  logic [5:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  frame_release;
  logic [3:0]            rd_seq;
  logic                  err_drop;
  logic [7:0]            drop_count;
  logic [DATA_WIDTH-1:0] stat_mean;
  logic [DATA_WIDTH-1:0] stat_min;

  modport master (
    output snr_in, snr_index, snr_valid, snr_frame_done,
    output rd_en, rd_addr, frame_release,
    input  frame_avail, rd_data, rd_seq, err_drop, drop_count,
    input  stat_mean, stat_min
  );

  modport slave (
    input  snr_in, snr_index, snr_valid, snr_frame_done,
    input  rd_en, rd_addr, frame_release,
    output frame_avail, rd_data, rd_seq, err_drop, drop_count,
    output stat_mean, stat_min
  );
endinterface

// File: rtl/nanomamba_snr_frame_collector.sv
// nanomamba_snr_frame_collector
// Receive-side endpoint for the per-mel-band SNR stream. Each frame must
// deliver bands 0..N_MELS-1 strictly in order; good frames are committed
// into a two-bank ping-pong buffer, anything else is dropped and counted.
// The consumer reads the oldest committed frame by band address and frees
// it with frame_release.
// Ports: clk, rst_n (async, active-low) and the slave modport of
// nanomamba_snr_frame_collector_if (stream in, read port, release
// handshake, drop pulse/counter, per-frame statistics).
// Optional feature: define SNR_FRAME_STATS_EN to build the frame mean/min
// statistics; without it stat_mean/stat_min are tied to zero.
module nanomamba_snr_frame_collector #(
  parameter int N_MELS     = 40,
  parameter int DATA_WIDTH = 8,
  parameter int RECIP      = 1639
) (
  input logic clk,
  input logic rst_n,
  nanomamba_snr_frame_collector_if.slave bus
);
  localparam logic [5:0] NM = 6'(N_MELS);

  logic [DATA_WIDTH-1:0] mem_q [2][N_MELS];
  logic [1:0]            full_q, full_d;
  logic [3:0]            seq_q [2];
  logic [3:0]            seq_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [5:0]            exp_idx_q, exp_idx_d, exp_idx_eff_s;
  logic                  bad_q, bad_d, bad_eff_s;
  logic [3:0]            commit_seq_q, commit_seq_d;
  logic [7:0]            drop_count_q, drop_count_d;
  logic                  err_drop_q;
  logic                  frame_avail_q;
  logic [3:0]            rd_seq_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  accept_s, commit_s, drop_s, release_s;

  // Sample acceptance, commit/drop decision and next state of the control registers
  always_comb begin
    accept_s      = bus.snr_valid && (bus.snr_index == exp_idx_q) &&
                    (exp_idx_q < NM) && !full_q[wr_bank_q];
    // The same-cycle sample counts toward the frame_done decision.
    exp_idx_eff_s = exp_idx_q + (accept_s ? 6'd1 : 6'd0);
    bad_eff_s     = bad_q | (bus.snr_valid & ~accept_s);
    commit_s      = bus.snr_frame_done && (exp_idx_eff_s == NM) &&
                    !bad_eff_s && !full_q[wr_bank_q];
    drop_s        = bus.snr_frame_done && !commit_s;
    release_s     = bus.frame_release && full_q[rd_bank_q];

    // Commit and release always hit different banks, so both masks apply.
    full_d        = (full_q & ~(release_s ? (2'b01 << rd_bank_q) : 2'b00)) |
                    (commit_s ? (2'b01 << wr_bank_q) : 2'b00);
    seq_d         = seq_q;
    seq_d[wr_bank_q] = commit_s ? commit_seq_q : seq_q[wr_bank_q];
    wr_bank_d     = wr_bank_q ^ commit_s;
    rd_bank_d     = rd_bank_q ^ release_s;
    exp_idx_d     = bus.snr_frame_done ? 6'd0 : exp_idx_eff_s;
    bad_d         = bus.snr_frame_done ? 1'b0 : bad_eff_s;
    commit_seq_d  = commit_s ? (commit_seq_q + 4'd1) : commit_seq_q;
    drop_count_d  = (drop_s && (drop_count_q != 8'hFF)) ? (drop_count_q + 8'd1) : drop_count_q;

    if (!bus.rd_en) begin
      rd_data_d = rd_data_q;
    end else if (full_q[rd_bank_q] && (bus.rd_addr < NM)) begin
      rd_data_d = mem_q[rd_bank_q][bus.rd_addr];
    end else begin
      rd_data_d = '0;
    end
  end

  // Control registers and registered read-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q        <= 2'b00;
      seq_q[0]      <= 4'd0;
      seq_q[1]      <= 4'd0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      exp_idx_q     <= 6'd0;
      bad_q         <= 1'b0;
      commit_seq_q  <= 4'd0;
      drop_count_q  <= 8'd0;
      err_drop_q    <= 1'b0;
      frame_avail_q <= 1'b0;
      rd_seq_q      <= 4'd0;
      rd_data_q     <= '0;
    end else begin
      full_q        <= full_d;
      seq_q         <= seq_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      exp_idx_q     <= exp_idx_d;
      bad_q         <= bad_d;
      commit_seq_q  <= commit_seq_d;
      drop_count_q  <= drop_count_d;
      err_drop_q    <= drop_s;
      // Registered from next state so a commit/release is visible at T+1.
      frame_avail_q <= full_d[rd_bank_d];
      rd_seq_q      <= seq_d[rd_bank_d];
      rd_data_q     <= rd_data_d;
    end
  end

  // Frame storage; contents of an empty bank are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_bank_q][exp_idx_q] <= bus.snr_in;
    end
  end

  assign bus.frame_avail = frame_avail_q;
  assign bus.rd_seq      = rd_seq_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.err_drop    = err_drop_q;
  assign bus.drop_count  = drop_count_q;

`ifdef SNR_FRAME_STATS_EN
  logic [13:0]           sum_q, sum_d, sum_eff_s;
  logic [DATA_WIDTH-1:0] min_q, min_d, min_eff_s;
  logic [DATA_WIDTH-1:0] stat_mean_q, stat_mean_d;
  logic [DATA_WIDTH-1:0] stat_min_q, stat_min_d;
  logic [24:0]           prod_s;

  // Running sum/min including the current sample; mean via reciprocal multiply
  always_comb begin
    sum_eff_s   = sum_q + (accept_s ? 14'(bus.snr_in) : 14'd0);
    min_eff_s   = (accept_s && (bus.snr_in < min_q)) ? bus.snr_in : min_q;
    prod_s      = {11'd0, sum_eff_s} * 25'(RECIP);
    sum_d       = bus.snr_frame_done ? 14'd0 : sum_eff_s;
    min_d       = bus.snr_frame_done ? {DATA_WIDTH{1'b1}} : min_eff_s;
    stat_mean_d = commit_s ? prod_s[16 +: DATA_WIDTH] : stat_mean_q;
    stat_min_d  = commit_s ? min_eff_s : stat_min_q;
  end

  // Statistics registers; published values change only on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= 14'd0;
      min_q       <= {DATA_WIDTH{1'b1}};
      stat_mean_q <= '0;
      stat_min_q  <= '0;
    end else begin
      sum_q       <= sum_d;
      min_q       <= min_d;
      stat_mean_q <= stat_mean_d;
      stat_min_q  <= stat_min_d;
    end
  end

  assign bus.stat_mean = stat_mean_q;
  assign bus.stat_min  = stat_min_q;
`else
  assign bus.stat_mean = '0;
  assign bus.stat_min  = '0;
`endif
endmodule

// File: tb/tb_nanomamba_snr_frame_collector.sv
`timescale 1ns/1ps
module tb_nanomamba_snr_frame_collector;
  localparam int N     = 40;
  localparam int DW    = 8;
  localparam int RECIP = 1639;
`ifdef SNR_FRAME_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanomamba_snr_frame_collector_if #(.DATA_WIDTH(DW)) bus ();

  nanomamba_snr_frame_collector #(.N_MELS(N), .DATA_WIDTH(DW), .RECIP(RECIP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: a FIFO of committed frames plus the list of samples
  // received for the frame in flight, judged as a whole at frame_done.
  typedef struct { int data[64]; int seq; } frame_t;
  frame_t fq[$];
  int     cur_idx[$];
  int     cur_val[$];
  bit     cur_bad;
  int     cseq, m_drop, m_rd, m_mean, m_min;
  bit     m_err;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     fr_idx[$];
  int     fr_val[$];

  typedef struct { bit v; int idx; int val; bit done; bit rel; bit re; int ra; } cyc_t;

  task automatic model_clear();
    fq.delete(); cur_idx.delete(); cur_val.delete();
    cur_bad = 0; cseq = 0; m_drop = 0; m_rd = 0; m_mean = 0; m_min = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    bus.snr_in = '0; bus.snr_index = 6'd0; bus.snr_valid = 1'b0; bus.snr_frame_done = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = 6'd0; bus.frame_release = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock of stimulus; the model advances using the pre-edge state.
  task automatic drive(input bit v, input int idx, input int d, input bit done,
                       input bit rel, input bit re, input int ra);
    int pre, sum, mn;
    bit good;
    frame_t f;
    pre = fq.size();
    bus.snr_valid = v; bus.snr_index = idx[5:0]; bus.snr_in = d[DW-1:0];
    bus.snr_frame_done = done; bus.frame_release = rel;
    bus.rd_en = re; bus.rd_addr = ra[5:0];
    if (re) m_rd = (pre > 0 && ra < N) ? fq[0].data[ra] : 0;
    if (v) begin
      cur_idx.push_back(idx); cur_val.push_back(d);
      if (pre == 2) cur_bad = 1;
    end
    m_err = 0;
    if (done) begin
      good = !cur_bad && pre < 2 && cur_idx.size() == N;
      for (int i = 0; i < cur_idx.size(); i++) if (cur_idx[i] != i) good = 0;
      if (good) begin
        sum = 0; mn = 255;
        for (int i = 0; i < N; i++) begin
          f.data[i] = cur_val[i]; sum += cur_val[i];
          if (cur_val[i] < mn) mn = cur_val[i];
        end
        f.seq = cseq; cseq = (cseq + 1) % 16;
        fq.push_back(f);
        if (STATS != 0) begin
          m_mean = (((sum * RECIP) % (1 << 25)) >> 16) % 256;
          m_min  = mn;
        end
      end else begin
        m_err = 1;
        if (m_drop < 255) m_drop++;
      end
      cur_idx.delete(); cur_val.delete(); cur_bad = 0;
    end
    if (rel && pre > 0) fq.pop_front();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Plays fr_idx/fr_val as one frame; done optionally merged with last sample.
  task automatic play_frame(input bit merge, input bit rel_at_done);
    for (int i = 0; i < fr_idx.size(); i++)
      drive(1'b1, fr_idx[i], fr_val[i], merge && (i == fr_idx.size() - 1),
            merge && rel_at_done && (i == fr_idx.size() - 1), 1'b0, 0);
    if (!merge || fr_idx.size() == 0) drive(1'b0, 0, 0, 1'b1, rel_at_done, 1'b0, 0);
  endtask

  task automatic make_frame(input int mul, input int add);
    fr_idx.delete(); fr_val.delete();
    for (int i = 0; i < N; i++) begin
      fr_idx.push_back(i); fr_val.push_back((i * mul + add) % 256);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.frame_avail !== 1'b0) $display("FAIL reset_avail: got %0b want 0", bus.frame_avail); else n_pass++;
    n_checks++; if (bus.rd_data !== 8'd0) $display("FAIL reset_rd_data: got %0d want 0", bus.rd_data); else n_pass++;
    n_checks++; if (bus.rd_seq !== 4'd0) $display("FAIL reset_rd_seq: got %0d want 0", bus.rd_seq); else n_pass++;
    n_checks++; if (bus.err_drop !== 1'b0) $display("FAIL reset_err_drop: got %0b want 0", bus.err_drop); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'd0) $display("FAIL reset_drop_count: got %0d want 0", bus.drop_count); else n_pass++;
    n_checks++; if (bus.stat_mean !== 8'd0 || bus.stat_min !== 8'd0)
      $display("FAIL reset_stats: got mean %0d min %0d want 0 0", bus.stat_mean, bus.stat_min); else n_pass++;
  endtask

  task automatic test_good_frame();
    do_reset();
    make_frame(3, 0);
    play_frame(1'b0, 1'b0);
    n_checks++; if (bus.frame_avail !== 1'b1) $display("FAIL good_avail: got %0b want 1", bus.frame_avail); else n_pass++;
    n_checks++; if (bus.rd_seq !== 4'd0) $display("FAIL good_seq: got %0d want 0", bus.rd_seq); else n_pass++;
    n_checks++; if (bus.stat_mean !== 8'(STATS * 58)) $display("FAIL good_mean: got %0d want %0d", bus.stat_mean, STATS * 58); else n_pass++;
    n_checks++; if (bus.stat_min !== 8'd0) $display("FAIL good_min: got %0d want 0", bus.stat_min); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 13);
    n_checks++; if (bus.rd_data !== 8'd39) $display("FAIL good_read13: got %0d want 39", bus.rd_data); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    n_checks++; if (bus.rd_data !== 8'd39) $display("FAIL good_read_hold: got %0d want 39", bus.rd_data); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 45);
    n_checks++; if (bus.rd_data !== 8'd0) $display("FAIL good_read_oob: got %0d want 0", bus.rd_data); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    n_checks++; if (bus.frame_avail !== 1'b0) $display("FAIL good_release: got %0b want 0", bus.frame_avail); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 13);
    n_checks++; if (bus.rd_data !== 8'd0) $display("FAIL good_read_empty: got %0d want 0", bus.rd_data); else n_pass++;
  endtask

  task automatic test_misorder();
    do_reset();
    make_frame(1, 7);
    fr_idx[6] = 5;
    play_frame(1'b0, 1'b0);
    n_checks++; if (bus.err_drop !== 1'b1) $display("FAIL mis_err_drop: got %0b want 1", bus.err_drop); else n_pass++;
    n_checks++; if (bus.drop_count !== 8'd1) $display("FAIL mis_drop_count: got %0d want 1", bus.drop_count); else n_pass++;
    n_checks++; if (bus.frame_avail !== 1'b0) $display("FAIL mis_avail: got %0b want 0", bus.frame_avail); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    n_checks++; if (bus.err_drop !== 1'b0) $display("FAIL mis_err_pulse: got %0b want 0", bus.err_drop); else n_pass++;
    make_frame(2, 1);
    play_frame(1'b0, 1'b0);
    n_checks++; if (bus.frame_avail !== 1'b1 || bus.rd_seq !== 4'd0)
      $display("FAIL mis_next_seq: got avail %0b seq %0d want 1 0", bus.frame_avail, bus.rd_seq); else n_pass++;
    fr_idx.delete(); fr_val.delete();
    play_frame(1'b0, 1'b0);
    n_checks++; if (bus.drop_count !== 8'd2) $display("FAIL mis_empty_frame: got %0d want 2", bus.drop_count); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    make_frame(1, 1);   play_frame(1'b0, 1'b0);
    make_frame(2, 0);   play_frame(1'b0, 1'b0);
    make_frame(1, 100); play_frame(1'b0, 1'b0);
    n_checks++; if (bus.err_drop !== 1'b1 || bus.drop_count !== 8'd1)
      $display("FAIL ovf_drop: got err %0b count %0d want 1 1", bus.err_drop, bus.drop_count); else n_pass++;
    n_checks++; if (bus.frame_avail !== 1'b1 || bus.rd_seq !== 4'd0)
      $display("FAIL ovf_first: got avail %0b seq %0d want 1 0", bus.frame_avail, bus.rd_seq); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 7);
    n_checks++; if (bus.rd_data !== 8'd8) $display("FAIL ovf_read_a: got %0d want 8", bus.rd_data); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    n_checks++; if (bus.frame_avail !== 1'b1 || bus.rd_seq !== 4'd1)
      $display("FAIL ovf_second: got avail %0b seq %0d want 1 1", bus.frame_avail, bus.rd_seq); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 7);
    n_checks++; if (bus.rd_data !== 8'd14) $display("FAIL ovf_read_b: got %0d want 14", bus.rd_data); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    n_checks++; if (bus.frame_avail !== 1'b0) $display("FAIL ovf_drained: got %0b want 0", bus.frame_avail); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    make_frame(0, 128);
    play_frame(1'b1, 1'b0);
    n_checks++; if (bus.frame_avail !== 1'b1 || bus.err_drop !== 1'b0)
      $display("FAIL same_commit: got avail %0b err %0b want 1 0", bus.frame_avail, bus.err_drop); else n_pass++;
    n_checks++; if (bus.stat_mean !== 8'(STATS * 128) || bus.stat_min !== 8'(STATS * 128))
      $display("FAIL same_stats: got mean %0d min %0d want %0d", bus.stat_mean, bus.stat_min, STATS * 128); else n_pass++;
  endtask

  task automatic test_release_edges();
    do_reset();
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    n_checks++; if (bus.frame_avail !== 1'b0 || bus.drop_count !== 8'd0)
      $display("FAIL rel_empty: got avail %0b drops %0d want 0 0", bus.frame_avail, bus.drop_count); else n_pass++;
    make_frame(1, 0);  play_frame(1'b0, 1'b0);
    make_frame(1, 50); play_frame(1'b0, 1'b1);
    n_checks++; if (bus.frame_avail !== 1'b1 || bus.rd_seq !== 4'd1)
      $display("FAIL rel_with_commit: got avail %0b seq %0d want 1 1", bus.frame_avail, bus.rd_seq); else n_pass++;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 5);
    n_checks++; if (bus.rd_data !== 8'd55) $display("FAIL rel_read: got %0d want 55", bus.rd_data); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    make_frame(1, 9); play_frame(1'b0, 1'b0);
    fr_idx.delete(); fr_val.delete(); play_frame(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, i, i, 1'b0, 1'b0, 1'b0, 0);
    bus.snr_valid = 1'b1; bus.snr_index = 6'd20;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.frame_avail !== 1'b0 || bus.drop_count !== 8'd0)
      $display("FAIL rst_async: got avail %0b drops %0d want 0 0", bus.frame_avail, bus.drop_count); else n_pass++;
    idle_inputs(); model_clear();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    make_frame(1, 3); play_frame(1'b0, 1'b0);
    n_checks++; if (bus.frame_avail !== 1'b1 || bus.rd_seq !== 4'd0 || bus.drop_count !== 8'd0)
      $display("FAIL rst_fresh: got avail %0b seq %0d drops %0d want 1 0 0", bus.frame_avail, bus.rd_seq, bus.drop_count); else n_pass++;
  endtask

  // Random frames (good, missing, duplicated, overrun, empty, merged done),
  // back-to-back or with gaps, random reads/releases; checked every cycle.
  task automatic test_random();
    cyc_t st[$];
    cyc_t c;
    int kind, k;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      fr_idx.delete(); fr_val.delete();
      if (kind != 4) for (int i = 0; i < N; i++) begin
        fr_idx.push_back(i); fr_val.push_back($urandom_range(0, 255));
      end
      k = $urandom_range(1, N - 1);
      if (kind == 1) begin fr_idx.delete(k); fr_val.delete(k); end
      if (kind == 2) fr_idx[k] = k - 1;
      if (kind == 3) begin fr_idx.push_back($urandom_range(N, 63)); fr_val.push_back(1); end
      for (int i = 0; i < fr_idx.size(); i++) begin
        c.v = 1'b1; c.idx = fr_idx[i]; c.val = fr_val[i];
        c.done = (kind == 5) && (i == fr_idx.size() - 1);
        c.rel = ($urandom_range(0, 39) == 0); c.re = $urandom_range(0, 1); c.ra = $urandom_range(0, 47);
        st.push_back(c);
      end
      if (kind != 5) begin
        c.v = 1'b0; c.idx = 0; c.val = 0; c.done = 1'b1;
        c.rel = ($urandom_range(0, 3) == 0); c.re = 1'b0; c.ra = 0;
        st.push_back(c);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        c.v = 1'b0; c.idx = 0; c.val = 0; c.done = 1'b0;
        c.rel = $urandom_range(0, 1); c.re = $urandom_range(0, 1); c.ra = $urandom_range(0, 47);
        st.push_back(c);
      end
    end
    foreach (st[i]) begin
      drive(st[i].v, st[i].idx, st[i].val, st[i].done, st[i].rel, st[i].re, st[i].ra);
      n_checks++; if (bus.frame_avail !== (fq.size() > 0))
        $display("FAIL rnd_avail@%0d: got %0b want %0b", i, bus.frame_avail, fq.size() > 0); else n_pass++;
      if (fq.size() > 0) begin
        n_checks++; if (bus.rd_seq !== 4'(fq[0].seq))
          $display("FAIL rnd_seq@%0d: got %0d want %0d", i, bus.rd_seq, fq[0].seq); else n_pass++;
      end
      n_checks++; if (bus.rd_data !== 8'(m_rd)) $display("FAIL rnd_rd_data@%0d: got %0d want %0d", i, bus.rd_data, m_rd); else n_pass++;
      n_checks++; if (bus.err_drop !== m_err) $display("FAIL rnd_err@%0d: got %0b want %0b", i, bus.err_drop, m_err); else n_pass++;
      n_checks++; if (bus.drop_count !== 8'(m_drop)) $display("FAIL rnd_drops@%0d: got %0d want %0d", i, bus.drop_count, m_drop); else n_pass++;
      n_checks++; if (bus.stat_mean !== 8'(m_mean) || bus.stat_min !== 8'(m_min))
        $display("FAIL rnd_stats@%0d: got %0d/%0d want %0d/%0d", i, bus.stat_mean, bus.stat_min, m_mean, m_min); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_misorder();
    test_overflow();
    test_same_cycle();
    test_release_edges();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
